kernel_host_driver: RTL

- Host-side sequencer for a synthesized kernel that exposes `r_enable`/`w_enable`/`result` and a `controlArr` control port onto its internal array `a`.
- Per command it:
  1. streams N input words into the kernel array through the control port;
  2. pulses `r_enable` with the initial arguments;
  3. waits for `w_enable`;
  4. reads the N array words back out as a valid/ready stream;
  5. emits a status beat.
- It sits between the system stream fabric and one kernel instance.

---
 rtl/kernel_host_driver_if.sv | 50 +++++
 rtl/kernel_host_driver.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/kernel_host_driver_if.sv
// Host-side bundle for kernel_host_driver: command, load stream, readback
// stream and status channels, each with a valid/ready handshake.
interface kernel_host_driver_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDR_W:0]          cmd_len;
    logic [ADDR_W-1:0]        cmd_i;
    logic signed [DATA_W-1:0] cmd_acc;

    logic                     s_valid;
    logic                     s_ready;
    logic [DATA_W-1:0]        s_data;

    logic                     m_valid;
    logic                     m_ready;
    logic [DATA_W-1:0]        m_data;
    logic                     m_last;

    logic                     sts_valid;
    logic                     sts_ready;
    logic                     sts_result;
    logic                     sts_err;

    // Host / fabric side.
    modport master (
        output cmd_valid, cmd_len, cmd_i, cmd_acc,
        input  cmd_ready,
        output s_valid, s_data,
        input  s_ready,
        input  m_valid, m_data, m_last,
        output m_ready,
        input  sts_valid, sts_result, sts_err,
        output sts_ready
    );

    // Driver side.
    modport slave (
        input  cmd_valid, cmd_len, cmd_i, cmd_acc,
        output cmd_ready,
        input  s_valid, s_data,
        output s_ready,
        output m_valid, m_data, m_last,
        input  m_ready,
        output sts_valid, sts_result, sts_err,
        input  sts_ready
    );
endinterface

// File: rtl/kernel_host_driver.sv
// Host-side sequencer for one kernel instance: loads the kernel array, starts
// the kernel, waits for done, streams the array back and reports status.
module kernel_host_driver #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1000,
    parameter int TIMEOUT = 1000000
) (
    input  logic                clk,
    input  logic                rst_n,
    kernel_host_driver_if.slave host,
    output logic                r_enable,
    input  logic                w_enable,
    input  logic                result,
    output logic [ADDR_W-1:0]   init_i_t_a,
    output logic [DATA_W-1:0]   init_acc_t_a,
    output logic                controlArr,
    output logic                controlArrWEnable_a,
    output logic [ADDR_W-1:0]   controlArrAddr_a,
    output logic [DATA_W-1:0]   controlArrWData_a,
    input  logic [DATA_W-1:0]   controlArrRData_a
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [TMO_W-1:0] TIMEOUT_C = TMO_W'(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_RD_ADDR,
        S_RD_DATA,
        S_RD_OUT,
        S_STATUS
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  len_q, len_m1, cnt_q;
    logic [ADDR_W-1:0] arg_i_q;
    logic [DATA_W-1:0] arg_acc_q;
    logic [TMO_W-1:0]  tmo_q, tmo_inc;
    logic [DATA_W-1:0] m_data_q;
    logic              m_last_q, sts_result_q, sts_err_q;

    logic len_bad, tmo_hit;
    logic cmd_ready_c, s_ready_c, m_valid_c, sts_valid_c;
    logic args_c;

    assign len_m1  = len_q - CNT_ONE;
    assign len_bad = (host.cmd_len == '0) || (host.cmd_len > DEPTH_C);
    assign tmo_inc = tmo_q + TMO_ONE;
    assign tmo_hit = (TIMEOUT != 0) && (tmo_inc == TIMEOUT_C);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt           = state;
        cmd_ready_c         = 1'b0;
        s_ready_c           = 1'b0;
        m_valid_c           = 1'b0;
        sts_valid_c         = 1'b0;
        args_c              = 1'b0;
        r_enable            = 1'b0;
        controlArr          = 1'b0;
        controlArrWEnable_a = 1'b0;
        controlArrAddr_a    = '0;
        controlArrWData_a   = '0;

        // Outputs stay at their idle values for the whole reset cycle.
        if (rst_n) begin
            case (state)
                S_IDLE: begin
                    cmd_ready_c = 1'b1;
                    if (host.cmd_valid) state_nxt = len_bad ? S_STATUS : S_LOAD;
                end
                S_LOAD: begin
                    controlArr          = 1'b1;
                    s_ready_c           = 1'b1;
                    controlArrAddr_a    = cnt_q[ADDR_W-1:0];
                    controlArrWEnable_a = host.s_valid;
                    controlArrWData_a   = host.s_data;
                    if (host.s_valid && (cnt_q == len_m1)) state_nxt = S_START;
                end
                S_START: begin
                    r_enable  = 1'b1;
                    args_c    = 1'b1;
                    state_nxt = S_RUN;
                end
                S_RUN: begin
                    // Done beats timeout when both land in the same cycle.
                    args_c = 1'b1;
                    if (w_enable)     state_nxt = S_RD_ADDR;
                    else if (tmo_hit) state_nxt = S_STATUS;
                end
                S_RD_ADDR: begin
                    controlArr       = 1'b1;
                    controlArrAddr_a = cnt_q[ADDR_W-1:0];
                    state_nxt        = S_RD_DATA;
                end
                S_RD_DATA: begin
                    controlArr       = 1'b1;
                    controlArrAddr_a = cnt_q[ADDR_W-1:0];
                    state_nxt        = S_RD_OUT;
                end
                S_RD_OUT: begin
                    m_valid_c = 1'b1;
                    if (host.m_ready) state_nxt = m_last_q ? S_STATUS : S_RD_ADDR;
                end
                S_STATUS: begin
                    sts_valid_c = 1'b1;
                    if (host.sts_ready) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q        <= '0;
            cnt_q        <= '0;
            arg_i_q      <= '0;
            arg_acc_q    <= '0;
            tmo_q        <= '0;
            m_data_q     <= '0;
            m_last_q     <= 1'b0;
            sts_result_q <= 1'b0;
            sts_err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (host.cmd_valid) begin
                        len_q        <= host.cmd_len;
                        arg_i_q      <= host.cmd_i;
                        arg_acc_q    <= host.cmd_acc;
                        cnt_q        <= '0;
                        sts_result_q <= 1'b0;
                        sts_err_q    <= len_bad;
                    end
                end
                S_LOAD: begin
                    if (host.s_valid) cnt_q <= cnt_q + CNT_ONE;
                end
                S_START: tmo_q <= '0;
                S_RUN: begin
                    tmo_q <= tmo_inc;
                    if (w_enable) begin
                        sts_result_q <= result;
                        cnt_q        <= '0;
                    end else if (tmo_hit) begin
                        sts_err_q <= 1'b1;
                    end
                end
                S_RD_DATA: begin
                    m_data_q <= controlArrRData_a;
                    m_last_q <= (cnt_q == len_m1);
                end
                S_RD_OUT: begin
                    if (host.m_ready) cnt_q <= cnt_q + CNT_ONE;
                end
                S_STATUS: begin
                    if (host.sts_ready) sts_err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign host.cmd_ready  = cmd_ready_c;
    assign host.s_ready    = s_ready_c;
    assign host.m_valid    = m_valid_c;
    assign host.sts_valid  = sts_valid_c;
    assign host.m_data     = rst_n ? m_data_q : '0;
    assign host.m_last     = rst_n & m_last_q;
    assign host.sts_result = rst_n & sts_result_q;
    assign host.sts_err    = rst_n & sts_err_q;

    assign init_i_t_a   = args_c ? arg_i_q   : '0;
    assign init_acc_t_a = args_c ? arg_acc_q : '0;

endmodule
